vx_exec_dispatch_arb: RTL and testbench

- Shares one execute-unit dispatch port between NUM_REQS requesters (issue slots), using round-robin arbitration.
- Supports multi-beat operations (e.g. tensor ops): the grant stays locked to one requester until its last beat is accepted.
- A 2-entry elastic output buffer decouples the requesters from unit backpressure.
- A saturating stall counter feeds the pipeline perf CSRs.
- Sits between the dispatch stage and a single shared execute block.

---
 rtl/vx_exec_dispatch_arb.sv | 144 ++++++++++++++
 tb/tb_vx_exec_dispatch_arb.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_exec_dispatch_arb.sv
// Round-robin arbiter sharing one execute dispatch port among NUM_REQS issue slots,
// with grant locking for multi-beat ops, a 2-entry output buffer and a saturating stall counter.
module vx_exec_dispatch_arb #(
    parameter int NUM_REQS   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int PERF_CTR_W = 32,
    parameter int SEL_W      = $clog2(NUM_REQS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQS-1:0]            req_valid,
    input  logic [NUM_REQS*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQS-1:0]            req_last,
    output logic [NUM_REQS-1:0]            req_ready,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_last,
    output logic [SEL_W-1:0]               out_sel,
    input  logic                           out_ready,
    output logic [PERF_CTR_W-1:0]          stall_count
);

    // Handshake: a beat moves when valid & ready in the same cycle; valid never waits on ready,
    // and ready here is derived only from registered state, never from out_ready.

    localparam logic [SEL_W:0]   NREQ     = (SEL_W+1)'(NUM_REQS);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REQS - 1);

    logic [SEL_W-1:0]      rr_ptr;
    logic                  locked;
    logic [SEL_W-1:0]      lock_idx;

    logic [DATA_WIDTH-1:0] buf_data [2];
    logic                  buf_last [2];
    logic [SEL_W-1:0]      buf_sel  [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;
    logic [1:0]            count_nxt;
    logic                  full;

    logic [NUM_REQS-1:0]   grant;
    logic [SEL_W-1:0]      grant_idx;
    logic                  found;
    logic [SEL_W:0]        scan_sum;
    logic [SEL_W-1:0]      scan_idx;
    logic                  accept;
    logic                  pop;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  push_last;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        scan_sum  = '0;
        scan_idx  = '0;
        if (!reset && !full) begin
            if (locked) begin
                grant[lock_idx] = 1'b1;
                grant_idx       = lock_idx;
            end else begin
                for (int k = 0; k < NUM_REQS; k++) begin
                    scan_sum = {1'b0, rr_ptr} + (SEL_W+1)'(k);
                    if (scan_sum >= NREQ) scan_sum = scan_sum - NREQ;
                    scan_idx = scan_sum[SEL_W-1:0];
                    if (!found && req_valid[scan_idx]) begin
                        found           = 1'b1;
                        grant[scan_idx] = 1'b1;
                        grant_idx       = scan_idx;
                    end
                end
            end
        end
    end

    always_comb begin
        push_data = '0;
        push_last = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (grant[i]) begin
                push_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                push_last = req_last[i];
            end
        end
    end

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);
    assign pop       = out_valid & out_ready;

    always_comb begin
        count_nxt = count;
        case ({accept, pop})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr      <= '0;
            locked      <= 1'b0;
            lock_idx    <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= '0;
            full        <= 1'b0;
            stall_count <= '0;
            for (int e = 0; e < 2; e++) begin
                buf_data[e] <= '0;
                buf_last[e] <= 1'b0;
                buf_sel[e]  <= '0;
            end
        end else begin
            if (accept) begin
                buf_data[wr_ptr] <= push_data;
                buf_last[wr_ptr] <= push_last;
                buf_sel[wr_ptr]  <= grant_idx;
                wr_ptr           <= ~wr_ptr;
                if (push_last) begin
                    locked <= 1'b0;
                    rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                end else begin
                    locked   <= 1'b1;
                    lock_idx <= grant_idx;
                end
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count_nxt;
            full  <= (count_nxt == 2'd2);
            // Stall: someone wants the port but nothing moved (full buffer or idle lock holder).
            if (|req_valid && !accept && stall_count != '1)
                stall_count <= stall_count + 1'b1;
        end
    end

    assign out_valid = (count != 2'd0);
    assign out_data  = out_valid ? buf_data[rd_ptr] : '0;
    assign out_last  = out_valid ? buf_last[rd_ptr] : 1'b0;
    assign out_sel   = out_valid ? buf_sel[rd_ptr]  : '0;

endmodule

// File: tb/tb_vx_exec_dispatch_arb.sv
// Bench for vx_exec_dispatch_arb: scripted per-requester beat queues drive the DUT while a
// transaction-level model (queue buffer, rotating priority, lock owner) predicts every output.
module tb_vx_exec_dispatch_arb;

    localparam int N  = 4;
    localparam int DW = 64;

    typedef struct packed {
        logic          v;
        logic          l;
        logic [DW-1:0] d;
    } beat_t;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic [1:0]      out_sel;
    logic            out_ready;
    logic [31:0]     stall_count;

    logic [N-1:0]    s_req_ready;
    logic            s_out_valid;
    logic [DW-1:0]   s_out_data;
    logic            s_out_last;
    logic [1:0]      s_out_sel;
    logic [3:0]      s_stall_count;

    vx_exec_dispatch_arb dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last), .out_sel(out_sel),
        .out_ready(out_ready), .stall_count(stall_count)
    );

    vx_exec_dispatch_arb #(.PERF_CTR_W(4)) dut_sat (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(s_req_ready), .out_valid(s_out_valid),
        .out_data(s_out_data), .out_last(s_out_last), .out_sel(s_out_sel),
        .out_ready(out_ready), .stall_count(s_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    beat_t       src_q [N][$];
    logic [66:0] exp_q[$];
    int          m_rr;
    bit          m_locked;
    int          m_lock_idx;
    longint      m_stall;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_rr       = 0;
        m_locked   = 0;
        m_lock_idx = 0;
        m_stall    = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                req_valid[i]          = src_q[i][0].v;
                req_last[i]           = src_q[i][0].l;
                req_data[i*DW +: DW]  = src_q[i][0].d;
            end else begin
                req_valid[i]          = 1'b0;
                req_last[i]           = 1'b0;
                req_data[i*DW +: DW]  = '0;
            end
        end
    endtask

    // One clock: drive, check all outputs against the model, advance model and scripts.
    task automatic cycle();
        logic [N-1:0] g;
        int           gi;
        bit           acc;
        logic [66:0]  head;
        drive();
        #1;
        g  = '0;
        gi = -1;
        if (!reset && exp_q.size() < 2) begin
            if (m_locked) gi = m_lock_idx;
            else
                for (int k = 0; k < N; k++)
                    if (gi < 0 && req_valid[(m_rr + k) % N]) gi = (m_rr + k) % N;
        end
        if (gi >= 0) g[gi] = 1'b1;
        acc  = (gi >= 0) && req_valid[gi];
        head = (exp_q.size() > 0) ? exp_q[0] : '0;
        check("req_ready", 64'(req_ready), 64'(g));
        check("ready_onehot", 64'($onehot0(req_ready)), 64'd1);
        check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
        check("out_data", out_data, head[63:0]);
        check("out_sel", 64'(out_sel), 64'(head[65:64]));
        check("out_last", 64'(out_last), 64'(head[66]));
        check("stall_count", 64'(stall_count), 64'(m_stall));
        check("stall_sat", 64'(s_stall_count), 64'((m_stall > 15) ? 15 : m_stall));
        if (reset) begin
            model_reset();
        end else begin
            if (req_valid != '0 && !acc) m_stall++;
            if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
            if (acc) begin
                exp_q.push_back({req_last[gi], 2'(gi), req_data[gi*DW +: DW]});
                if (req_last[gi]) begin
                    m_locked = 0;
                    m_rr     = (gi + 1) % N;
                end else begin
                    m_locked   = 1;
                    m_lock_idx = gi;
                end
            end
        end
        for (int i = 0; i < N; i++)
            if (src_q[i].size() > 0 && (!src_q[i][0].v || (acc && gi == i)))
                void'(src_q[i].pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int  n;
        bit  busy;
        n    = 0;
        busy = 1;
        while (busy && n < budget) begin
            busy = exp_q.size() > 0;
            for (int i = 0; i < N; i++) if (src_q[i].size() > 0) busy = 1;
            if (busy) begin
                cycle();
                n++;
            end
        end
        check({tag, "_drain_timeout"}, 64'(n < budget), 64'd1);
    endtask

    task automatic add_beat(input int r, input logic l, input logic [DW-1:0] d);
        src_q[r].push_back({1'b1, l, d});
    endtask

    task automatic add_gap(input int r);
        src_q[r].push_back({1'b0, 1'b0, {DW{1'b0}}});
    endtask

    task automatic add_random_op(input int r);
        int len;
        len = $urandom_range(1, 3);
        for (int b = 0; b < len; b++) begin
            if ($urandom_range(0, 3) == 0) add_gap(r);
            add_beat(r, (b == len - 1), {$urandom, $urandom});
        end
    endtask

    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        out_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        cycle();
        reset = 1'b0;

        // Single stream from requester 2.
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) add_beat(2, 1'b1, 64'h10 + 64'(k));
        run_until_idle("single", 40);
        check("single_no_stall", 64'(stall_count), 64'd0);

        // All four requesters contend with single-beat ops.
        for (int k = 0; k < 6; k++)
            for (int r = 0; r < N; r++) add_beat(r, 1'b1, {$urandom, $urandom});
        run_until_idle("rr", 80);

        // Requester 1 locks for 3 beats with a 2-cycle idle gap; requester 0 waits.
        add_beat(1, 1'b0, 64'hA1);
        add_gap(1);
        add_gap(1);
        add_beat(1, 1'b0, 64'hA2);
        add_beat(1, 1'b1, 64'hA3);
        add_gap(0);
        for (int k = 0; k < 3; k++) add_beat(0, 1'b1, 64'hB0 + 64'(k));
        run_until_idle("lock", 40);

        // Backpressure: buffer fills, requester 0 stalls, then drains.
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) add_beat(0, 1'b1, 64'hC0 + 64'(k));
        for (int k = 0; k < 6; k++) cycle();
        out_ready = 1'b1;
        run_until_idle("bp", 40);

        // Reset in the middle of a 3-beat op from requester 3.
        out_ready = 1'b0;
        add_beat(3, 1'b0, 64'hD0);
        add_beat(3, 1'b0, 64'hD1);
        add_beat(3, 1'b1, 64'hD2);
        for (int k = 0; k < 3; k++) cycle();
        reset = 1'b1;
        for (int r = 0; r < N; r++) src_q[r].delete();
        cycle();
        reset = 1'b0;
        add_beat(1, 1'b1, 64'hE1);
        add_beat(3, 1'b1, 64'hE3);
        out_ready = 1'b1;
        run_until_idle("post_reset", 40);

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < N; r++)
                if (src_q[r].size() == 0 && $urandom_range(0, 1) == 1) add_random_op(r);
            cycle();
        end
        out_ready = 1'b1;
        run_until_idle("random", 400);

        // Stall counter saturation on the 4-bit instance.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 25; k++) add_beat(0, 1'b1, 64'hF00 + 64'(k));
        for (int k = 0; k < 22; k++) cycle();
        check("sat_hold_15", 64'(s_stall_count), 64'd15);
        check("wide_ctr_20", 64'(stall_count), 64'd20);
        out_ready = 1'b1;
        run_until_idle("sat", 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
